ps2_scancode_decoder: RTL

Downstream consumer of the PS/2 keyboard receiver. It takes one validated scan-code byte per strobe and folds the scan-code set 2 prefix bytes (E0, F0, E1) into single key events. Each event carries make/break, extended, typematic-repeat and ASCII information. The block also keeps shift state, the currently held key and a count of distinct key presses, which feed the display/CPU side of the design.

---
 rtl/ps2_scancode_decoder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: folds E0/F0/E1 prefixes into single key events
// and tracks shift, the held key and a press counter.
module ps2_scancode_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             code_valid,
  input  logic [7:0]       code,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic [7:0]       evt_ascii,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic             shift,
  output logic [CNT_W-1:0] press_cnt
);

  typedef enum logic [2:0] {IDLE, E0, F0, E0F0, SKIP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             evt_valid_q, evt_ext_q, evt_break_q, evt_repeat_q;
  logic [7:0]       evt_code_q, evt_ascii_q;
  logic             key_down_q, shl_q, shr_q;
  logic [8:0]       held_q;
  logic [CNT_W-1:0] cnt_q;

  logic emit, emit_ext, emit_brk;
  logic is_pfx, is_junk, is_mod, match;

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic sh);
    logic [7:0] lc, oth;
    lc = 8'h00;
    case (c)
      8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
      8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
      8'h43: lc = 8'h69;  8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
      8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;  8'h4D: lc = 8'h70;
      8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;  8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;
      8'h3C: lc = 8'h75;  8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
      8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
      default: lc = 8'h00;
    endcase
    oth = 8'h00;
    case (c)
      8'h45: oth = 8'h30;  8'h16: oth = 8'h31;  8'h1E: oth = 8'h32;  8'h26: oth = 8'h33;
      8'h25: oth = 8'h34;  8'h2E: oth = 8'h35;  8'h36: oth = 8'h36;  8'h3D: oth = 8'h37;
      8'h3E: oth = 8'h38;  8'h46: oth = 8'h39;
      8'h29: oth = 8'h20;  8'h5A: oth = 8'h0D;  8'h66: oth = 8'h08;
      default: oth = 8'h00;
    endcase
    if (lc != 8'h00) return sh ? (lc - 8'h20) : lc;
    return oth;
  endfunction

  assign is_pfx  = (code == 8'hE0) || (code == 8'hF0) || (code == 8'hE1);
  assign is_junk = (code == 8'h00) || (code == 8'hFF);

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (code_valid && !is_junk) begin
      case (state_q)
        IDLE: begin
          if (code == 8'hE0)      state_d = E0;
          else if (code == 8'hF0) state_d = F0;
          else if (code == 8'hE1) begin
            state_d = SKIP;
            skip_d  = 3'd7;
          end else emit = 1'b1;
        end
        E0: begin
          if (code == 8'hF0)      state_d = E0F0;
          else if (code != 8'hE0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        F0, E0F0: begin
          // A prefix after F0 is a protocol error: drop it and resync.
          state_d = IDLE;
          if (!is_pfx) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = (state_q == E0F0);
          end
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign is_mod = !emit_ext && ((code == 8'h12) || (code == 8'h59));
  assign match  = key_down_q && (held_q == {emit_ext, code});

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      skip_q       <= 3'd0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= 8'h00;
      evt_ext_q    <= 1'b0;
      evt_break_q  <= 1'b0;
      evt_repeat_q <= 1'b0;
      evt_ascii_q  <= 8'h00;
      key_down_q   <= 1'b0;
      held_q       <= 9'h000;
      shl_q        <= 1'b0;
      shr_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      evt_valid_q <= emit;
      if (emit) begin
        evt_code_q   <= code;
        evt_ext_q    <= emit_ext;
        evt_break_q  <= emit_brk;
        evt_repeat_q <= !emit_brk && !is_mod && match;
        evt_ascii_q  <= emit_ext ? 8'h00 : ascii_of(code, shl_q | shr_q);
        if (is_mod) begin
          if (code == 8'h12) shl_q <= !emit_brk;
          else               shr_q <= !emit_brk;
        end else if (!emit_brk) begin
          if (!match) begin
            cnt_q      <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            held_q     <= {emit_ext, code};
            key_down_q <= 1'b1;
          end
        end else if (match) begin
          key_down_q <= 1'b0;
          held_q     <= 9'h000;
        end
      end
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_code_q;
  assign evt_ext    = evt_ext_q;
  assign evt_break  = evt_break_q;
  assign evt_repeat = evt_repeat_q;
  assign evt_ascii  = evt_ascii_q;
  assign key_down   = key_down_q;
  assign held_code  = held_q[7:0];
  assign shift      = shl_q | shr_q;
  assign press_cnt  = cnt_q;

endmodule
